// File: rtl/mux_scan_pkg.sv
// Shared definitions for one-hot-select mux controllers: widths, FSM
// encoding and the index-to-one-hot decode.
package mux_scan_pkg;

  localparam int SEL_W = 8;
  localparam int IDX_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRIVE  = 2'd1,
    FINISH = 2'd2
  } state_e;

  function automatic logic [SEL_W-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [SEL_W-1:0] one;
    one = SEL_W'(1);
    return one << idx;
  endfunction

endpackage

// File: rtl/settle_timer.sv
// Hold-window timer: counts enabled cycles and pulses expire_o on the
// SETTLE-th one, then restarts from zero.
module settle_timer #(
  parameter int SETTLE = 1
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  logic [3:0] cnt_q;

  assign expire_o = en_i && (cnt_q == 4'(SETTLE - 1));

  // NOTE: sequential state is written with <= so every flop samples the
  // pre-edge values; blocking assignments here would create ordering races.
  always_ff @(posedge CLK) begin
    if (!RST_N || clr_i || expire_o) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + 4'd1;
    end
  end

endmodule

// File: rtl/mux_scan_ctrl.sv
// Select generator / result collector for the 8:1 one-hot mux: scans all
// inputs into a byte or reads a single input, with start/busy/done handshake.
module mux_scan_ctrl
  import mux_scan_pkg::*;
#(
  parameter int SETTLE = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             START,
  input  logic             SINGLE,
  input  logic [IDX_W-1:0] IDX,
  input  logic             O,
  output logic [SEL_W-1:0] S,
  output logic [SEL_W-1:0] Q,
  output logic             BUSY,
  output logic             DONE
);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   k_q, k_d;
  logic               single_q, single_d;
  logic [SEL_W-1:0]   shadow_q, shadow_d;
  logic [SEL_W-1:0]   q_q, q_d;
  logic               expire;

  settle_timer #(.SETTLE(SETTLE)) u_timer (
    .CLK      (CLK),
    .RST_N    (RST_N),
    .clr_i    (state_q != DRIVE),
    .en_i     (state_q == DRIVE),
    .expire_o (expire)
  );

  // NOTE: every variable gets its hold value first so no path through the
  // case leaves one unassigned, which would otherwise infer a latch.
  always_comb begin
    state_d  = state_q;
    k_d      = k_q;
    single_d = single_q;
    shadow_d = shadow_q;
    q_d      = q_q;
    unique case (state_q)
      IDLE, FINISH: begin
        state_d = IDLE;
        if (START) begin
          single_d = SINGLE;
          k_d      = SINGLE ? IDX : '0;
          shadow_d = '0;
          state_d  = DRIVE;
        end
      end
      DRIVE: begin
        if (expire) begin
          if (single_q) begin
            shadow_d = {{(SEL_W-1){1'b0}}, O};
            q_d      = shadow_d;
            state_d  = FINISH;
          end else begin
            shadow_d[k_q] = O;
            if (k_q == IDX_W'(SEL_W - 1)) begin
              q_d     = shadow_d;
              state_d = FINISH;
            end else begin
              k_d = k_q + 1'b1;
            end
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q  <= IDLE;
      k_q      <= '0;
      single_q <= 1'b0;
      shadow_q <= '0;
      q_q      <= '0;
    end else begin
      state_q  <= state_d;
      k_q      <= k_d;
      single_q <= single_d;
      shadow_q <= shadow_d;
      q_q      <= q_d;
    end
  end

  assign S    = (state_q == DRIVE) ? onehot(k_q) : '0;
  assign BUSY = (state_q == DRIVE);
  assign DONE = (state_q == FINISH);
  assign Q    = q_q;

endmodule

// File: tb/tb_mux_scan_ctrl.sv
// Bench for mux_scan_ctrl: three instances (SETTLE = 1, 3, 2) each behind a
// behavioural 8:1 one-hot mux, directed scenarios plus random requests.
module tb_mux_scan_ctrl;

  localparam logic [11:0] SETS = {4'd2, 4'd3, 4'd1};

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start  [3];
  logic       single [3];
  logic [2:0] idx    [3];
  logic [7:0] mux_in [3];
  logic       o      [3];
  logic [7:0] s      [3];
  logic [7:0] q      [3];
  logic       busy   [3];
  logic       done   [3];
  logic [7:0] last_q [3];
  bit         armed = 1'b0;
  int         n_checks = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    mux_scan_ctrl #(.SETTLE(int'(SETS[g*4 +: 4]))) u_dut (
      .CLK    (clk),
      .RST_N  (rst_n),
      .START  (start[g]),
      .SINGLE (single[g]),
      .IDX    (idx[g]),
      .O      (o[g]),
      .S      (s[g]),
      .Q      (q[g]),
      .BUSY   (busy[g]),
      .DONE   (done[g])
    );
    assign o[g] = |(mux_in[g] & s[g]);
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Select bus must always be zero or one-hot.
  always @(negedge clk) begin
    if (armed) begin
      for (int g = 0; g < 3; g++) begin
        check($sformatf("onehot_inv[%0d]", g), 8'($countones(s[g]) <= 1), 8'd1);
      end
    end
  end

  function automatic logic [7:0] exp_sel(input int settle, input bit sgl,
                                         input logic [2:0] ix, input int c);
    logic [7:0] one;
    one = 8'h01;
    if (sgl) return one << ix;
    return one << ((c - 1) / settle);
  endfunction

  // Issue a request at the current negedge (cycle 0) and check every cycle up
  // to and including the DONE cycle. poke > 0 pulses START in that cycle.
  task automatic run_req(input int g, input bit sgl, input logic [2:0] ix,
                         input logic [7:0] data, input int poke);
    int         settle;
    int         n;
    logic [7:0] exp_q;
    settle    = int'(SETS[g*4 +: 4]);
    n         = sgl ? settle : 8 * settle;
    exp_q     = sgl ? {7'b0, data[ix]} : data;
    mux_in[g] = data;
    single[g] = sgl;
    idx[g]    = ix;
    start[g]  = 1'b1;
    for (int c = 1; c <= n; c++) begin
      @(negedge clk);
      start[g] = 1'b0;
      check($sformatf("sel[%0d] c%0d", g, c), s[g], exp_sel(settle, sgl, ix, c));
      check($sformatf("busy[%0d] c%0d", g, c), 8'(busy[g]), 8'd1);
      check($sformatf("done_lo[%0d] c%0d", g, c), 8'(done[g]), 8'd0);
      check($sformatf("q_hold[%0d] c%0d", g, c), q[g], last_q[g]);
      if (c == poke) begin
        start[g]  = 1'b1;
        single[g] = 1'b1;
        idx[g]    = 3'($urandom_range(0, 7));
      end
    end
    @(negedge clk);
    start[g] = 1'b0;
    check($sformatf("sel_idle[%0d]", g), s[g], 8'h00);
    check($sformatf("busy_lo[%0d]", g), 8'(busy[g]), 8'd0);
    check($sformatf("done[%0d]", g), 8'(done[g]), 8'd1);
    check($sformatf("q[%0d]", g), q[g], exp_q);
    last_q[g] = exp_q;
  endtask

  task automatic check_idle(input string tag);
    for (int g = 0; g < 3; g++) begin
      check($sformatf("%s s[%0d]", tag, g), s[g], 8'h00);
      check($sformatf("%s busy[%0d]", tag, g), 8'(busy[g]), 8'd0);
      check($sformatf("%s done[%0d]", tag, g), 8'(done[g]), 8'd0);
      check($sformatf("%s q[%0d]", tag, g), q[g], last_q[g]);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) begin
      start[g]  = 1'b0;
      single[g] = 1'b0;
      idx[g]    = 3'd0;
      mux_in[g] = 8'h00;
      last_q[g] = 8'h00;
    end
    repeat (2) @(negedge clk);
    armed = 1'b1;
    check_idle("reset");
    rst_n = 1'b1;
    @(negedge clk);

    // H-only scan, SETTLE = 1.
    run_req(0, 1'b0, 3'd0, 8'h80, 0);
    @(negedge clk);
    // Alternating pattern, SETTLE = 3.
    run_req(1, 1'b0, 3'd0, 8'h55, 0);
    @(negedge clk);
    // Single reads, SETTLE = 2.
    run_req(2, 1'b1, 3'd7, 8'h80, 0);
    @(negedge clk);
    run_req(2, 1'b1, 3'd3, 8'hF7, 0);
    @(negedge clk);

    // START while busy is ignored; START in the DONE cycle chains a request.
    run_req(0, 1'b0, 3'd0, 8'hA3, 4);
    run_req(0, 1'b0, 3'd0, 8'h3C, 0);
    @(negedge clk);
    check_idle("after_chain");

    // Reset in cycle 5 of a scan aborts it.
    mux_in[0] = 8'hFF;
    single[0] = 1'b0;
    start[0]  = 1'b1;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      start[0] = 1'b0;
      check($sformatf("rst_scan sel c%0d", c), s[0], exp_sel(1, 1'b0, 3'd0, c));
    end
    rst_n = 1'b0;
    for (int g = 0; g < 3; g++) last_q[g] = 8'h00;
    for (int c = 6; c <= 9; c++) begin
      @(negedge clk);
      check_idle($sformatf("mid_rst c%0d", c));
    end
    rst_n = 1'b1;
    run_req(0, 1'b0, 3'd0, 8'h5A, 0);
    @(negedge clk);
    check_idle("after_rst");

    // Random requests, sometimes chained back-to-back.
    for (int i = 0; i < 24; i++) begin
      int g;
      g = int'($urandom_range(0, 2));
      run_req(g, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
              8'($urandom), ($urandom_range(0, 3) == 0) ? 2 : 0);
      if ($urandom_range(0, 1) == 1) @(negedge clk);
    end
    @(negedge clk);
    check_idle("final");

    armed = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/mux_scan_ctrl.md
# mux_scan_ctrl

Sequential select generator and result collector for the 8-to-1 one-hot-select bit mux (`mux8b1`). It drives the mux's 8-bit one-hot `S` bus and samples the mux output `O`. In scan mode it walks all eight inputs (A..H) and assembles them into a byte. In single mode it reads one chosen input. It sits directly upstream (select producer) and downstream (output consumer) of the mux, with a start/busy/done handshake to the controlling logic.

## Interface
Parameters:
- `SETTLE`, default 1, range 1..15: number of cycles each one-hot select is held before `O` is sampled.

Ports:
- `CLK`  in  1  rising-edge clock, the only clock.
- `RST_N`  in  1  reset; synchronous, active-low.
- `START`  in  1  request; sampled only in IDLE.
- `SINGLE`  in  1  mode, sampled with START: 1 = read one input, 0 = scan all eight.
- `IDX`  in  3  input index for single mode, sampled with START (0 = A … 7 = H).
- `O`  in  1  mux output.
- `S`  out  8  one-hot select to the mux; 8'h00 when idle.
- `Q`  out  8  result byte, registered.
- `BUSY`  out  1  high while a request is in progress.
- `DONE`  out  1  one-cycle pulse when `Q` has been updated.

## Operation
- States: IDLE, DRIVE, FINISH.
- **IDLE**
  - Outputs: S = 0, BUSY = 0.
  - On START = 1, latch SINGLE and IDX, clear the settle counter and the shadow byte, then go to DRIVE.
  - Initial select: k = IDX in single mode, k = 0 in scan mode.
- **DRIVE**
  - Outputs: S = 8'h01 << k, BUSY = 1.
  - The settle counter counts 1..SETTLE.
  - On the edge where the count reaches SETTLE, write O into shadow bit k (scan) or shadow bit 0 (single).
  - Scan mode: if k < 7, increment k, reset the counter and stay in DRIVE; if k = 7, go to FINISH.
  - Single mode: go to FINISH.
- **FINISH** (one cycle)
  - Outputs: S = 0, BUSY = 0, DONE = 1.
  - Q is loaded from the shadow byte on the edge entering FINISH.
  - Next state is IDLE.
  - START is accepted in FINISH exactly as in IDLE, so back-to-back requests are possible.
- Bit mapping:
  - Scan: Q[k] = value of input k (A → Q[0], H → Q[7]).
  - Single: Q = {7'b0, input IDX}.
- S is always either zero or exactly one-hot; it never changes except at a select-advance edge.
- START while BUSY = 1 is ignored: no queueing and no effect on the running request.
- Q holds its value between DONE pulses. It is never partially updated mid-scan.
- Reset (RST_N = 0 at an edge), including mid-scan:
  - Outputs: S = 0, Q = 8'h00, BUSY = 0, DONE = 0.
  - Internal: state = IDLE, counter = 0, k = 0, shadow = 0.
  - The in-flight request is aborted and no DONE is produced.

## Timing
- Call the edge at which START is sampled edge 0.
- Scan mode:
  - S = 1 << k is driven during cycles k·SETTLE+1 … (k+1)·SETTLE.
  - O is sampled at the end of cycle (k+1)·SETTLE.
  - DONE = 1 and the new Q are valid in cycle 8·SETTLE+1.
- Single mode: S is valid in cycles 1..SETTLE; DONE and Q are valid in cycle SETTLE+1.
- The mux is combinational, so O must be stable within the hold window. SETTLE = 1 is sufficient for the current mux.
- BUSY rises in cycle 1 and falls in the DONE cycle. DONE is never high while BUSY is high.

## Structure
- Shared package `mux_scan_pkg` holds:
  - SEL_W = 8 and IDX_W = 3;
  - the state encoding (IDLE, DRIVE, FINISH);
  - a one-hot decode function (index → 8-bit one-hot), reused by other one-hot-select mux controllers.
- Sub-module `settle_timer`: a 4-bit up-counter with clear, parameterised by SETTLE, producing a one-cycle `expire` pulse.
- All other logic (FSM, k register, shadow and Q registers) lives in `mux_scan_ctrl`.
- Target size is about 150–250 lines.

## Test plan
Each test connects `mux8b1` behind the block.
- **H-only scan.** SETTLE = 1; A..G = 0, H = 1; START with SINGLE = 0.
  - S = 01, 02, …, 80 in cycles 1..8.
  - DONE in cycle 9 with Q = 8'h80; BUSY is high in cycles 1..8.
- **Alternating pattern with slow settle.** SETTLE = 3; A, C, E, G = 1 and the others 0; scan.
  - Each S value is held 3 cycles.
  - DONE in cycle 25 with Q = 8'h55.
- **Single read.** SETTLE = 2; single mode, IDX = 7, H = 1.
  - S = 8'h80 in cycles 1..2.
  - DONE in cycle 3 with Q = 8'h01.
  - Repeat with IDX = 3 and D = 0: Q = 8'h00.
- **START while busy.** Scan running; pulse START with SINGLE = 1 at cycle 4.
  - The S sequence is unaffected and only one DONE occurs (cycle 9).
  - START asserted in the DONE cycle begins a new request, with S = 8'h01 the next cycle.
- **Reset mid-scan.** RST_N = 0 at cycle 5 of a scan.
  - From cycle 6: S = 0, Q = 0, BUSY = 0, DONE never pulses.
  - After release, a new scan completes normally.
- **Select invariant check.** A continuous assertion, active in every test, that S is 0 or one-hot (popcount ≤ 1).
